// File: rtl/skew_pkg.sv
// Shared definitions for the skew monitor: FSM state encoding and default
// widths and limits.
package skew_pkg;

  localparam int unsigned TSKEW_DEF    = 5;
  localparam int unsigned MAX_WAIT_DEF = 15;
  localparam int unsigned CNT_W_DEF    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD1 = 2'd1,
    LEAD2 = 2'd2
  } skew_state_e;

endpackage

// File: rtl/skew_edge_det.sv
// Rising-edge detector for one monitored input.
// Build option: SKEW_SYNC_EN adds a 2-flop synchronizer in front of the
// detector. The synchronizer flops are not reset.
module skew_edge_det (
  input  logic clk,
  input  logic sig_in,
  output logic rise
);

  logic sig_s;
  logic prev_d, prev_q;

`ifdef SKEW_SYNC_EN
  logic [1:0] sync_d, sync_q;

  // Shift the raw input through the synchronizer.
  always_comb sync_d = {sync_q[0], sig_in};

  // Synchronizer register. It is deliberately left without reset.
  always_ff @(posedge clk) sync_q <= sync_d;

  assign sig_s = sync_q[1];
`else
  assign sig_s = sig_in;
`endif

  // The previous-value register always loads the current level. Reset
  // needs no special branch because it would also load the current level,
  // so a level held high across reset produces no edge afterwards.
  always_comb prev_d = sig_s;

  // Previous-value register.
  always_ff @(posedge clk) prev_q <= prev_d;

  assign rise = sig_s & ~prev_q;

endmodule

// File: rtl/skew_monitor.sv
// Run-time skew checker. It measures the distance in clk cycles between
// matching rising edges on sig_in1 and sig_in2, in either order, and flags
// excessive skew or a missing partner edge.
// Build option: SKEW_SYNC_EN enables input synchronizers, which add 2
// cycles of detection latency. When it is enabled, reset must be held for
// at least 3 cycles.
module skew_monitor
  import skew_pkg::*;
#(
  parameter int unsigned TSKEW    = TSKEW_DEF,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in1,
  input  logic             sig_in2,
  input  logic             clear_in,
  output logic [CNT_W-1:0] skew_out,
  output logic             lead_out,
  output logic             valid_out,
  output logic             viol_out,
  output logic             timeout_out,
  output logic             sticky_out
);

  logic rise1, rise2;
  logic partner_rise, own_rise;

  skew_state_e      state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [CNT_W-1:0] skew_d, skew_q;
  logic             lead_d, lead_q;
  logic             valid_d, valid_q;
  logic             viol_d, viol_q;
  logic             timeout_d, timeout_q;
  logic             sticky_d, sticky_q;

  skew_edge_det u_det1 (.clk(clk), .sig_in(sig_in1), .rise(rise1));
  skew_edge_det u_det2 (.clk(clk), .sig_in(sig_in2), .rise(rise2));

  // Split the edges into the lead side and the partner side for the current state.
  always_comb begin
    partner_rise = 1'b0;
    own_rise     = 1'b0;
    if (state_q == LEAD1) begin
      partner_rise = rise2;
      own_rise     = rise1;
    end else if (state_q == LEAD2) begin
      partner_rise = rise1;
      own_rise     = rise2;
    end
  end

  // Next-state logic for the measurement FSM, counter, outputs and sticky flag.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    skew_d    = skew_q;
    lead_d    = lead_q;
    valid_d   = 1'b0;
    viol_d    = 1'b0;
    timeout_d = 1'b0;
    // If a set and a clear arrive together, the set wins.
    sticky_d  = viol_q ? 1'b1 : (clear_in ? 1'b0 : sticky_q);

    unique case (state_q)
      IDLE: begin
        if (rise1 && rise2) begin
          skew_d  = '0;
          lead_d  = 1'b0;
          valid_d = 1'b1;
        end else if (rise1) begin
          state_d = LEAD1;
          cnt_d   = CNT_W'(1);
        end else if (rise2) begin
          state_d = LEAD2;
          cnt_d   = CNT_W'(1);
        end
      end
      LEAD1, LEAD2: begin
        if (partner_rise) begin
          skew_d  = cnt_q;
          lead_d  = (state_q == LEAD2);
          valid_d = 1'b1;
          viol_d  = (cnt_q > CNT_W'(TSKEW));
          state_d = IDLE;
          cnt_d   = '0;
        end else if (own_rise) begin
          cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_W'(MAX_WAIT)) begin
          timeout_d = 1'b1;
          viol_d    = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      skew_q    <= '0;
      lead_q    <= 1'b0;
      valid_q   <= 1'b0;
      viol_q    <= 1'b0;
      timeout_q <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      skew_q    <= skew_d;
      lead_q    <= lead_d;
      valid_q   <= valid_d;
      viol_q    <= viol_d;
      timeout_q <= timeout_d;
      sticky_q  <= sticky_d;
    end
  end

  assign skew_out    = skew_q;
  assign lead_out    = lead_q;
  assign valid_out   = valid_q;
  assign viol_out    = viol_q;
  assign timeout_out = timeout_q;
  assign sticky_out  = sticky_q;

endmodule

// File: tb/tb_skew_monitor.sv
// Self-checking bench for skew_monitor. It runs directed scenarios and then
// randomized strobes, and compares the outputs every cycle against a
// timestamp-based reference model.
module tb_skew_monitor;

  localparam int TSKEW    = 5;
  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 4;
`ifdef SKEW_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             sig_in1 = 1'b0;
  logic             sig_in2 = 1'b0;
  logic             clear_in = 1'b0;
  logic [CNT_W-1:0] skew_out;
  logic             lead_out, valid_out, viol_out, timeout_out, sticky_out;

  int errors = 0;
  int checks = 0;

  skew_monitor #(.TSKEW(TSKEW), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .sig_in1(sig_in1), .sig_in2(sig_in2),
    .clear_in(clear_in), .skew_out(skew_out), .lead_out(lead_out),
    .valid_out(valid_out), .viol_out(viol_out), .timeout_out(timeout_out),
    .sticky_out(sticky_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: it remembers which side opened a measurement and in
  // which cycle, and measures skew as the difference between cycle numbers.
  int cyc = 0;
  int pend = 0;
  int start = 0;
  bit p1 = 0, p2 = 0;
  bit dl1[2] = '{0, 0};
  bit dl2[2] = '{0, 0};
  int m_skew = 0, m_lead = 0, m_valid = 0, m_viol = 0, m_to = 0, m_sticky = 0;

  task automatic model_step(input bit a, input bit b, input bit clr, input bit rst);
    bit s1, s2, r1, r2, part, own;
    int d;
    if (LAT == 2) begin
      s1 = dl1[1]; s2 = dl2[1];
      dl1[1] = dl1[0]; dl1[0] = a;
      dl2[1] = dl2[0]; dl2[0] = b;
    end else begin
      s1 = a; s2 = b;
    end
    r1 = s1 && !p1;
    r2 = s2 && !p2;
    p1 = s1; p2 = s2;
    if (rst) begin
      pend = 0; m_skew = 0; m_lead = 0; m_valid = 0; m_viol = 0; m_to = 0; m_sticky = 0;
    end else begin
      if (m_viol != 0) m_sticky = 1;
      else if (clr) m_sticky = 0;
      m_valid = 0; m_viol = 0; m_to = 0;
      if (pend == 0) begin
        if (r1 && r2) begin m_skew = 0; m_lead = 0; m_valid = 1; end
        else if (r1) begin pend = 1; start = cyc; end
        else if (r2) begin pend = 2; start = cyc; end
      end else begin
        part = (pend == 1) ? r2 : r1;
        own  = (pend == 1) ? r1 : r2;
        d = cyc - start;
        if (part) begin
          m_skew = d; m_lead = (pend == 2); m_valid = 1; m_viol = (d > TSKEW); pend = 0;
        end else if (own) begin
          start = cyc;
        end else if (d >= MAX_WAIT) begin
          m_to = 1; m_viol = 1; pend = 0;
        end
      end
    end
    cyc++;
  endtask

  bit cur1 = 0, cur2 = 0;

  task automatic tick(input bit clr, input bit rst);
    sig_in1 = cur1; sig_in2 = cur2; clear_in = clr; reset = rst;
    @(posedge clk);
    #1;
    model_step(cur1, cur2, clr, rst);
    check("skew", int'(skew_out), m_skew);
    check("lead", int'(lead_out), m_lead);
    check("valid", int'(valid_out), m_valid);
    check("viol", int'(viol_out), m_viol);
    check("timeout", int'(timeout_out), m_to);
    check("sticky", int'(sticky_out), m_sticky);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  task automatic lower_both();
    cur1 = 0; cur2 = 0;
    idle(LAT + 2);
  endtask

  // Waits a bounded number of cycles for a measurement and checks it against fixed values.
  task automatic expect_meas(input string tag, input int sk, input int ld, input int vi);
    int n;
    n = 0;
    while (valid_out !== 1'b1 && n < LAT + 2) begin
      tick(1'b0, 1'b0);
      n++;
    end
    check({tag, "_valid"}, int'(valid_out), 1);
    check({tag, "_skew"}, int'(skew_out), sk);
    check({tag, "_lead"}, int'(lead_out), ld);
    check({tag, "_viol"}, int'(viol_out), vi);
  endtask

  initial begin
    int n, p;
    // Reset state.
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
    idle(2);
    check("rst_valid", int'(valid_out), 0);
    check("rst_sticky", int'(sticky_out), 0);
    check("rst_skew", int'(skew_out), 0);

    // Simultaneous edges.
    cur1 = 1; cur2 = 1; tick(1'b0, 1'b0);
    expect_meas("simul", 0, 0, 0);
    lower_both();

    // sig_in1 leads by 3.
    cur1 = 1; tick(1'b0, 1'b0); idle(2);
    cur2 = 1; tick(1'b0, 1'b0);
    expect_meas("lead1_3", 3, 0, 0);
    lower_both();

    // sig_in2 leads by 3.
    cur2 = 1; tick(1'b0, 1'b0); idle(2);
    cur1 = 1; tick(1'b0, 1'b0);
    expect_meas("lead2_3", 3, 1, 0);
    lower_both();

    // sig_in2 leads by 6: violation, sticky, then clear.
    cur2 = 1; tick(1'b0, 1'b0); idle(5);
    cur1 = 1; tick(1'b0, 1'b0);
    expect_meas("lead2_6", 6, 1, 1);
    tick(1'b0, 1'b0);
    check("sticky_set", int'(sticky_out), 1);
    tick(1'b1, 1'b0);
    check("sticky_clr", int'(sticky_out), 0);
    lower_both();

    // Missing partner: timeout after MAX_WAIT cycles.
    cur1 = 1; tick(1'b0, 1'b0);
    n = 0;
    while (timeout_out !== 1'b1 && n < MAX_WAIT + LAT + 5) begin
      tick(1'b0, 1'b0);
      n++;
    end
    check("timeout_dist", n, MAX_WAIT + LAT);
    check("timeout_viol", int'(viol_out), 1);
    check("timeout_valid", int'(valid_out), 0);
    lower_both();

    // Partner edge exactly at MAX_WAIT is a measurement.
    cur1 = 1; tick(1'b0, 1'b0); idle(MAX_WAIT - 1);
    cur2 = 1; tick(1'b0, 1'b0);
    expect_meas("edge_at_max", MAX_WAIT, 0, 1);
    check("edge_at_max_to", int'(timeout_out), 0);
    lower_both();
    tick(1'b1, 1'b0);

    // Levels held high through reset produce no edge.
    cur1 = 1; cur2 = 1;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0);
      n += int'(valid_out) + int'(viol_out);
    end
    check("high_thru_reset", n, 0);
    lower_both();

    // Reset in the middle of a measurement abandons it.
    cur1 = 1; tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    n = 0;
    for (int i = 0; i < MAX_WAIT + LAT + 4; i++) begin
      tick(1'b0, 1'b0);
      n += int'(valid_out) + int'(viol_out) + int'(timeout_out);
    end
    check("abandon_pulses", n, 0);
    lower_both();
    cur1 = 1; tick(1'b0, 1'b0); idle(2);
    cur2 = 1; tick(1'b0, 1'b0);
    expect_meas("after_abandon", 3, 0, 0);
    lower_both();

    // Randomized strobes with varying edge density, plus occasional clears and resets.
    for (int blk = 0; blk < 15; blk++) begin
      p = (blk % 3 == 0) ? 3 : ((blk % 3 == 1) ? 7 : 40);
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(p - 1) == 0) cur1 = ~cur1;
        if ($urandom_range(p - 1) == 0) cur2 = ~cur2;
        if ($urandom_range(399) == 0) begin
          for (int k = 0; k < 3; k++) tick(1'b0, 1'b1);
        end else begin
          tick($urandom_range(19) == 0, 1'b0);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
